// File: rtl/vehicle_guard_ctrl.sv
// Vehicle guard: per-core thermal shut-off with debounce/cool-down plus a fuel-qualified trip FSM.
// Optional THERMAL_STOP_EN: any core shut-off also suppresses keep_driving while in DRIVE.
module vehicle_guard_ctrl #(
  parameter int unsigned NCPU    = 4,
  parameter int unsigned DEB     = 3,
  parameter int unsigned COOL    = 8,
  parameter int unsigned CW      = 4,
  parameter int unsigned FUEL_W  = 8,
  parameter int unsigned RESERVE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCPU-1:0]   cpu_overheated,
  input  logic              arrived,
  input  logic [FUEL_W-1:0] fuel_level,
  input  logic              start,
  output logic [NCPU-1:0]   shut_off_computer,
  output logic              any_shutoff,
  output logic              keep_driving,
  output logic [1:0]        trip_state,
  output logic              stranded
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DRIVE    = 2'b01,
    DONE     = 2'b10,
    STRANDED = 2'b11
  } trip_e;

  localparam logic [CW-1:0]     DEB_LAST  = CW'(DEB - 1);
  localparam logic [CW-1:0]     COOL_LAST = CW'(COOL - 1);
  localparam logic [FUEL_W-1:0] RES_LVL   = FUEL_W'(RESERVE);

  logic [NCPU-1:0][CW-1:0] hot_cnt_q, hot_cnt_d;
  logic [NCPU-1:0][CW-1:0] cool_cnt_q, cool_cnt_d;
  logic [NCPU-1:0]         shut_q, shut_d;
  trip_e                   state_q, state_d;
  logic                    any_q, any_d;
  logic                    keep_q, keep_d;
  logic                    stranded_q, stranded_d;
  logic                    fuel_ok;

  // Per-core debounce: hot counter while running, cool counter while shut off.
  always_comb begin
    hot_cnt_d  = hot_cnt_q;
    cool_cnt_d = cool_cnt_q;
    shut_d     = shut_q;
    for (int i = 0; i < int'(NCPU); i++) begin
      if (!shut_q[i]) begin
        cool_cnt_d[i] = '0;
        if (!cpu_overheated[i]) begin
          hot_cnt_d[i] = '0;
        end else if (hot_cnt_q[i] >= DEB_LAST) begin
          shut_d[i]    = 1'b1;
          hot_cnt_d[i] = '0;
        end else begin
          hot_cnt_d[i] = hot_cnt_q[i] + CW'(1);
        end
      end else begin
        hot_cnt_d[i] = '0;
        if (cpu_overheated[i]) begin
          cool_cnt_d[i] = '0;
        end else if (cool_cnt_q[i] >= COOL_LAST) begin
          shut_d[i]     = 1'b0;
          cool_cnt_d[i] = '0;
        end else begin
          cool_cnt_d[i] = cool_cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign fuel_ok = (fuel_level > RES_LVL);

  // Trip FSM next state and registered-output next values.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start && !arrived && fuel_ok) state_d = DRIVE;
      DRIVE:    if (arrived) state_d = DONE;
                else if (!fuel_ok) state_d = STRANDED;
      DONE:     if (!arrived) state_d = IDLE;
      STRANDED: if (fuel_ok) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    any_d      = |shut_d;
    stranded_d = (state_d == STRANDED);
`ifdef THERMAL_STOP_EN
    keep_d     = (state_d == DRIVE) && !any_d;
`else
    keep_d     = (state_d == DRIVE);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hot_cnt_q  <= '0;
      cool_cnt_q <= '0;
      shut_q     <= '0;
      state_q    <= IDLE;
      any_q      <= 1'b0;
      keep_q     <= 1'b0;
      stranded_q <= 1'b0;
    end else begin
      hot_cnt_q  <= hot_cnt_d;
      cool_cnt_q <= cool_cnt_d;
      shut_q     <= shut_d;
      state_q    <= state_d;
      any_q      <= any_d;
      keep_q     <= keep_d;
      stranded_q <= stranded_d;
    end
  end

  assign shut_off_computer = shut_q;
  assign any_shutoff       = any_q;
  assign keep_driving      = keep_q;
  assign trip_state        = state_q;
  assign stranded          = stranded_q;

endmodule
